rv_decode: RTL and testbench

Instruction decode stage of the RV32I core, sitting directly upstream of the 32-entry register file. It accepts one fetched instruction per valid/ready handshake and drives the register-file read ports (rs1/rs2 index plus a one-cycle read strobe). It captures the registered operands one cycle later, generates the sign-extended immediate and control fields, and presents a registered operand bundle to execute under a valid/ready handshake.

---
 rtl/rv_decode_if.sv | 44 ++++
 rtl/rv_decode.sv | 163 ++++++++++++++++
 tb/tb_rv_decode.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rv_decode_if.sv
// Decode-stage bus: fetch handshake, register-file read port and execute bundle.
// Carries no logic of its own; timing is set by the modules attached to it.
// Flow control is valid/ready on fetch and execute; regLd is a one-cycle strobe.
interface rv_decode_if #(
  parameter int D_WIDTH = 32
);
  logic [31:0]        instrIn;
  logic               instrValid;
  logic               instrReady;
  logic               flush;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [4:0]         rd;
  logic               regLd;
  logic [D_WIDTH-1:0] rs1Dat;
  logic [D_WIDTH-1:0] rs2Dat;
  logic               exValid;
  logic               exReady;
  logic [D_WIDTH-1:0] exOp1;
  logic [D_WIDTH-1:0] exOp2;
  logic [D_WIDTH-1:0] exImm;
  logic [4:0]         exRd;
  logic [6:0]         exOpcode;
  logic [2:0]         exFunct3;
  logic               exFunct7b5;
  logic               exWbEn;
  logic               exIllegal;

  // Decoder side.
  modport master (
    input  instrIn, instrValid, flush, rs1Dat, rs2Dat, exReady,
    output instrReady, rs1, rs2, rd, regLd,
    output exValid, exOp1, exOp2, exImm, exRd, exOpcode, exFunct3,
    output exFunct7b5, exWbEn, exIllegal
  );

  // Fetch / register-file / execute side.
  modport slave (
    output instrIn, instrValid, flush, rs1Dat, rs2Dat, exReady,
    input  instrReady, rs1, rs2, rd, regLd,
    input  exValid, exOp1, exOp2, exImm, exRd, exOpcode, exFunct3,
    input  exFunct7b5, exWbEn, exIllegal
  );
endinterface

// File: rtl/rv_decode.sv
// RV32I decode: captures an instruction, strobes the regfile read, issues a registered operand bundle.
// Latency: exValid rises on the second edge after the accepting edge; at most one instruction per 4 cycles.
// Backpressure: bundle held stable in ISSUE until exReady; instrReady only in IDLE; flush returns to IDLE.
module rv_decode #(
  parameter int D_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  rv_decode_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RD, LATCH, ISSUE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic               ex_valid_q, ex_valid_d;
  logic [D_WIDTH-1:0] ex_op1_q, ex_op1_d;
  logic [D_WIDTH-1:0] ex_op2_q, ex_op2_d;
  logic [D_WIDTH-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]         ex_rd_q, ex_rd_d;
  logic [6:0]         ex_opcode_q, ex_opcode_d;
  logic [2:0]         ex_funct3_q, ex_funct3_d;
  logic               ex_funct7b5_q, ex_funct7b5_d;
  logic               ex_wb_en_q, ex_wb_en_d;
  logic               ex_illegal_q, ex_illegal_d;

  // Decoded view of the instruction register, consumed in LATCH.
  logic [D_WIDTH-1:0] imm_dec;
  logic               legal_dec;
  logic               wb_type_dec;
  logic               wb_en_dec;
  logic               sgn;

  assign sgn = instr_q[31];

  // Immediate format, legality and write-back class from the opcode.
  always_comb begin
    imm_dec     = '0;
    legal_dec   = 1'b1;
    wb_type_dec = 1'b0;
    case (instr_q[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        imm_dec     = {{(D_WIDTH-11){sgn}}, instr_q[30:20]};
        wb_type_dec = 1'b1;
      end
      7'b1110011: imm_dec = {{(D_WIDTH-11){sgn}}, instr_q[30:20]};
      7'b0100011: imm_dec = {{(D_WIDTH-11){sgn}}, instr_q[30:25], instr_q[11:7]};
      7'b1100011: imm_dec = {{(D_WIDTH-12){sgn}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
      7'b0110111, 7'b0010111: begin
        imm_dec     = {{(D_WIDTH-31){sgn}}, instr_q[30:12], 12'b0};
        wb_type_dec = 1'b1;
      end
      7'b1101111: begin
        imm_dec     = {{(D_WIDTH-20){sgn}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
        wb_type_dec = 1'b1;
      end
      7'b0110011: wb_type_dec = 1'b1;
      default:    legal_dec   = 1'b0;
    endcase
    // Every listed opcode already ends in 11; kept explicit so the rule survives opcode-table edits.
    if (instr_q[1:0] != 2'b11) legal_dec = 1'b0;
    if (!legal_dec) imm_dec = '0;
    wb_en_dec = legal_dec && wb_type_dec && (instr_q[11:7] != 5'd0);
  end

  // Next state and bundle capture; flush overrides everything and leaves the bundle fields untouched.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    ex_valid_d    = ex_valid_q;
    ex_op1_d      = ex_op1_q;
    ex_op2_d      = ex_op2_q;
    ex_imm_d      = ex_imm_q;
    ex_rd_d       = ex_rd_q;
    ex_opcode_d   = ex_opcode_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7b5_d = ex_funct7b5_q;
    ex_wb_en_d    = ex_wb_en_q;
    ex_illegal_d  = ex_illegal_q;
    if (bus.flush) begin
      state_d    = IDLE;
      ex_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.instrValid) begin
            instr_d = bus.instrIn;
            state_d = RD;
          end
        end
        RD: state_d = LATCH;
        LATCH: begin
          ex_op1_d      = bus.rs1Dat;
          ex_op2_d      = bus.rs2Dat;
          ex_imm_d      = imm_dec;
          ex_rd_d       = instr_q[11:7];
          ex_opcode_d   = instr_q[6:0];
          ex_funct3_d   = instr_q[14:12];
          ex_funct7b5_d = instr_q[30];
          ex_wb_en_d    = wb_en_dec;
          ex_illegal_d  = !legal_dec;
          ex_valid_d    = 1'b1;
          state_d       = ISSUE;
        end
        ISSUE: begin
          if (bus.exReady) begin
            ex_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, instruction register and execute bundle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      ex_valid_q    <= 1'b0;
      ex_op1_q      <= '0;
      ex_op2_q      <= '0;
      ex_imm_q      <= '0;
      ex_rd_q       <= '0;
      ex_opcode_q   <= '0;
      ex_funct3_q   <= '0;
      ex_funct7b5_q <= 1'b0;
      ex_wb_en_q    <= 1'b0;
      ex_illegal_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      ex_valid_q    <= ex_valid_d;
      ex_op1_q      <= ex_op1_d;
      ex_op2_q      <= ex_op2_d;
      ex_imm_q      <= ex_imm_d;
      ex_rd_q       <= ex_rd_d;
      ex_opcode_q   <= ex_opcode_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7b5_q <= ex_funct7b5_d;
      ex_wb_en_q    <= ex_wb_en_d;
      ex_illegal_q  <= ex_illegal_d;
    end
  end

  assign bus.instrReady = (state_q == IDLE);
  assign bus.regLd      = (state_q == RD);
  assign bus.rs1        = instr_q[19:15];
  assign bus.rs2        = instr_q[24:20];
  assign bus.rd         = instr_q[11:7];
  assign bus.exValid    = ex_valid_q;
  assign bus.exOp1      = ex_op1_q;
  assign bus.exOp2      = ex_op2_q;
  assign bus.exImm      = ex_imm_q;
  assign bus.exRd       = ex_rd_q;
  assign bus.exOpcode   = ex_opcode_q;
  assign bus.exFunct3   = ex_funct3_q;
  assign bus.exFunct7b5 = ex_funct7b5_q;
  assign bus.exWbEn     = ex_wb_en_q;
  assign bus.exIllegal  = ex_illegal_q;

endmodule

// File: tb/tb_rv_decode.sv
// Directed bench for rv_decode: reset, decode of each format, hold under backpressure, flush and mid-op reset.
module tb_rv_decode;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_decode_if #(.D_WIDTH(32)) bus ();
  rv_decode #(.D_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept an instruction and step to ISSUE (three edges); no checking here.
  task automatic accept_to_issue(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2);
    bus.instrIn    = ins;
    bus.instrValid = 1'b1;
    bus.rs1Dat     = d1;
    bus.rs2Dat     = d2;
    tick();
    bus.instrValid = 1'b0;
    tick();
    tick();
  endtask

  task automatic release_bundle();
    bus.exReady = 1'b1;
    tick();
    bus.exReady = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (bus.exValid !== 1'b0) begin n_fail++; $display("FAIL rst_exvalid: got %b want 0", bus.exValid); end
    n_checks++; if (bus.regLd !== 1'b0) begin n_fail++; $display("FAIL rst_regld: got %b want 0", bus.regLd); end
    n_checks++; if (bus.exOp1 !== 32'h0 || bus.exImm !== 32'h0) begin n_fail++; $display("FAIL rst_bundle: op1=%h imm=%h want 0", bus.exOp1, bus.exImm); end
    n_checks++; if (bus.rs1 !== 5'd0 || bus.rd !== 5'd0) begin n_fail++; $display("FAIL rst_idx: rs1=%0d rd=%0d want 0", bus.rs1, bus.rd); end
    #9 rst_n = 1'b1;
    tick();
    n_checks++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.instrReady); end
  endtask

  task automatic test_addi();
    bus.instrIn = 32'hFFF08293; bus.instrValid = 1'b1; bus.rs1Dat = 32'h10; bus.rs2Dat = 32'hABCD;
    n_checks++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL addi_ready: got %b want 1", bus.instrReady); end
    tick();
    bus.instrValid = 1'b0;
    n_checks++; if (bus.regLd !== 1'b1) begin n_fail++; $display("FAIL addi_regld_rd: got %b want 1", bus.regLd); end
    n_checks++; if (bus.rs1 !== 5'd1 || bus.rs2 !== 5'd31 || bus.rd !== 5'd5) begin n_fail++; $display("FAIL addi_idx: rs1=%0d rs2=%0d rd=%0d want 1 31 5", bus.rs1, bus.rs2, bus.rd); end
    n_checks++; if (bus.instrReady !== 1'b0 || bus.exValid !== 1'b0) begin n_fail++; $display("FAIL addi_rd_state: ready=%b valid=%b want 0 0", bus.instrReady, bus.exValid); end
    tick();
    n_checks++; if (bus.regLd !== 1'b0 || bus.exValid !== 1'b0) begin n_fail++; $display("FAIL addi_latch: regLd=%b valid=%b want 0 0", bus.regLd, bus.exValid); end
    tick();
    n_checks++; if (bus.exValid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", bus.exValid); end
    n_checks++; if (bus.exOp1 !== 32'h10 || bus.exOp2 !== 32'hABCD) begin n_fail++; $display("FAIL addi_ops: op1=%h op2=%h want 10 abcd", bus.exOp1, bus.exOp2); end
    n_checks++; if (bus.exImm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm: got %h want ffffffff", bus.exImm); end
    n_checks++; if (bus.exRd !== 5'd5 || bus.exWbEn !== 1'b1 || bus.exIllegal !== 1'b0) begin n_fail++; $display("FAIL addi_ctl: rd=%0d wb=%b ill=%b want 5 1 0", bus.exRd, bus.exWbEn, bus.exIllegal); end
    n_checks++; if (bus.exOpcode !== 7'h13 || bus.exFunct3 !== 3'b000 || bus.exFunct7b5 !== 1'b1) begin n_fail++; $display("FAIL addi_fields: opc=%h f3=%b f7b5=%b want 13 000 1", bus.exOpcode, bus.exFunct3, bus.exFunct7b5); end
    release_bundle();
    n_checks++; if (bus.exValid !== 1'b0 || bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL addi_release: valid=%b ready=%b want 0 1", bus.exValid, bus.instrReady); end
  endtask

  task automatic test_store();
    bus.instrIn = 32'h0021A423; bus.instrValid = 1'b1; bus.rs1Dat = 32'h100; bus.rs2Dat = 32'h22;
    tick();
    bus.instrValid = 1'b0;
    n_checks++; if (bus.rs1 !== 5'd3 || bus.rs2 !== 5'd2) begin n_fail++; $display("FAIL sw_idx: rs1=%0d rs2=%0d want 3 2", bus.rs1, bus.rs2); end
    tick();
    tick();
    n_checks++; if (bus.exImm !== 32'h8 || bus.exWbEn !== 1'b0 || bus.exFunct3 !== 3'b010) begin n_fail++; $display("FAIL sw_dec: imm=%h wb=%b f3=%b want 8 0 010", bus.exImm, bus.exWbEn, bus.exFunct3); end
    n_checks++; if (bus.exOp1 !== 32'h100 || bus.exOp2 !== 32'h22) begin n_fail++; $display("FAIL sw_ops: op1=%h op2=%h want 100 22", bus.exOp1, bus.exOp2); end
    release_bundle();
  endtask

  task automatic test_u_b_j();
    accept_to_issue(32'h123450B7, 32'h0, 32'h0);
    n_checks++; if (bus.exImm !== 32'h12345000 || bus.exWbEn !== 1'b1 || bus.exRd !== 5'd1) begin n_fail++; $display("FAIL lui: imm=%h wb=%b rd=%0d want 12345000 1 1", bus.exImm, bus.exWbEn, bus.exRd); end
    release_bundle();
    accept_to_issue(32'hFE000EE3, 32'h0, 32'h0);
    n_checks++; if (bus.exImm !== 32'hFFFFFFFC || bus.exWbEn !== 1'b0) begin n_fail++; $display("FAIL beq: imm=%h wb=%b want fffffffc 0", bus.exImm, bus.exWbEn); end
    release_bundle();
    accept_to_issue(32'h008000EF, 32'h0, 32'h0);
    n_checks++; if (bus.exImm !== 32'h8 || bus.exWbEn !== 1'b1 || bus.exRd !== 5'd1) begin n_fail++; $display("FAIL jal: imm=%h wb=%b rd=%0d want 8 1 1", bus.exImm, bus.exWbEn, bus.exRd); end
    release_bundle();
  endtask

  task automatic test_illegal();
    accept_to_issue(32'h00000000, 32'h5, 32'h6);
    n_checks++; if (bus.exValid !== 1'b1 || bus.exIllegal !== 1'b1 || bus.exWbEn !== 1'b0 || bus.exImm !== 32'h0) begin n_fail++; $display("FAIL ill_zero: valid=%b ill=%b wb=%b imm=%h want 1 1 0 0", bus.exValid, bus.exIllegal, bus.exWbEn, bus.exImm); end
    release_bundle();
    accept_to_issue(32'hFFF08290, 32'h0, 32'h0);
    n_checks++; if (bus.exIllegal !== 1'b1 || bus.exImm !== 32'h0 || bus.exWbEn !== 1'b0) begin n_fail++; $display("FAIL ill_low2: ill=%b imm=%h wb=%b want 1 0 0", bus.exIllegal, bus.exImm, bus.exWbEn); end
    release_bundle();
    accept_to_issue(32'h00000013, 32'h0, 32'h0);
    n_checks++; if (bus.exWbEn !== 1'b0 || bus.exIllegal !== 1'b0) begin n_fail++; $display("FAIL nop: wb=%b ill=%b want 0 0", bus.exWbEn, bus.exIllegal); end
    release_bundle();
  endtask

  task automatic test_back_to_back();
    accept_to_issue(32'hFFF08293, 32'h55, 32'h66);
    for (int i = 0; i < 5; i++) begin
      bus.instrValid = 1'b1;
      bus.instrIn    = 32'h0021A423;
      bus.rs1Dat     = 32'h99;
      tick();
      n_checks++; if (bus.exValid !== 1'b1 || bus.instrReady !== 1'b0) begin n_fail++; $display("FAIL hold_hs[%0d]: valid=%b ready=%b want 1 0", i, bus.exValid, bus.instrReady); end
      n_checks++; if (bus.exOp1 !== 32'h55 || bus.exImm !== 32'hFFFFFFFF || bus.exRd !== 5'd5 || bus.rs1 !== 5'd1) begin n_fail++; $display("FAIL hold_data[%0d]: op1=%h imm=%h rd=%0d rs1=%0d want 55 ffffffff 5 1", i, bus.exOp1, bus.exImm, bus.exRd, bus.rs1); end
    end
    bus.instrValid = 1'b0;
    release_bundle();
    n_checks++; if (bus.exValid !== 1'b0 || bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL hold_release: valid=%b ready=%b want 0 1", bus.exValid, bus.instrReady); end
    bus.instrValid = 1'b1;
    bus.instrIn    = 32'h0021A423;
    tick();
    bus.instrValid = 1'b0;
    n_checks++; if (bus.regLd !== 1'b1 || bus.rs1 !== 5'd3) begin n_fail++; $display("FAIL b2b_accept: regLd=%b rs1=%0d want 1 3", bus.regLd, bus.rs1); end
    tick();
    tick();
    n_checks++; if (bus.exValid !== 1'b1 || bus.exImm !== 32'h8) begin n_fail++; $display("FAIL b2b_issue: valid=%b imm=%h want 1 8", bus.exValid, bus.exImm); end
    release_bundle();
  endtask

  task automatic test_flush();
    bus.instrIn = 32'hFFF08293; bus.instrValid = 1'b1;
    tick();
    bus.instrValid = 1'b0;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++; if (bus.exValid !== 1'b0 || bus.regLd !== 1'b0 || bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL flush_latch: valid=%b regLd=%b ready=%b want 0 0 1", bus.exValid, bus.regLd, bus.instrReady); end
    tick();
    n_checks++; if (bus.exValid !== 1'b0) begin n_fail++; $display("FAIL flush_latch_late: valid=%b want 0", bus.exValid); end
    bus.flush = 1'b1; bus.instrValid = 1'b1; bus.instrIn = 32'h0021A423;
    tick();
    bus.flush = 1'b0; bus.instrValid = 1'b0;
    n_checks++; if (bus.regLd !== 1'b0 || bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL flush_idle: regLd=%b ready=%b want 0 1", bus.regLd, bus.instrReady); end
    accept_to_issue(32'h123450B7, 32'h0, 32'h0);
    bus.flush = 1'b1; bus.exReady = 1'b0;
    tick();
    bus.flush = 1'b0;
    n_checks++; if (bus.exValid !== 1'b0 || bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL flush_issue: valid=%b ready=%b want 0 1", bus.exValid, bus.instrReady); end
  endtask

  task automatic test_reset_mid();
    accept_to_issue(32'hFFF08293, 32'h77, 32'h88);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.exValid !== 1'b0 || bus.regLd !== 1'b0) begin n_fail++; $display("FAIL rstmid_hs: valid=%b regLd=%b want 0 0", bus.exValid, bus.regLd); end
    n_checks++; if (bus.exOp1 !== 32'h0 || bus.exImm !== 32'h0 || bus.exRd !== 5'd0 || bus.exWbEn !== 1'b0 || bus.rs1 !== 5'd0) begin n_fail++; $display("FAIL rstmid_data: op1=%h imm=%h rd=%0d wb=%b rs1=%0d want all 0", bus.exOp1, bus.exImm, bus.exRd, bus.exWbEn, bus.rs1); end
    #2 rst_n = 1'b1;
    tick();
    n_checks++; if (bus.instrReady !== 1'b1 || bus.exValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: ready=%b valid=%b want 1 0", bus.instrReady, bus.exValid); end
  endtask

  initial begin
    bus.instrIn    = 32'h0;
    bus.instrValid = 1'b0;
    bus.flush      = 1'b0;
    bus.rs1Dat     = 32'h0;
    bus.rs2Dat     = 32'h0;
    bus.exReady    = 1'b0;
    test_reset();
    test_addi();
    test_store();
    test_u_b_j();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
